bcci_axis_out_packer: RTL and testbench



---
 rtl/bcci_axis_out_packer_if.sv | 25 ++
 rtl/bcci_axis_out_packer.sv | 215 +++++++++++++++++++++
 tb/tb_bcci_axis_out_packer.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcci_axis_out_packer_if.sv
// Pixel-in handshake and AXI4-Stream beat-out signals of the bicubic output packer.
interface bcci_axis_out_packer_if #(
    parameter int PW = 24,
    parameter int DW = 96
) ();
    logic            in_valid;
    logic [PW-1:0]   in_data;
    logic            in_ready;
    logic            m_axis_tvalid;
    logic            m_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tkeep;
    logic            m_axis_tlast;
    logic            m_axis_tuser;

    modport master (
        input  in_valid, in_data, m_axis_tready,
        output in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
    );

    modport slave (
        output in_valid, in_data, m_axis_tready,
        input  in_ready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/bcci_axis_out_packer.sv
// Packs upscaled pixels into AXI4-Stream beats with line/frame framing and a
// first-word fall-through beat FIFO in front of the master port.
module bcci_axis_out_packer #(
    parameter int CHANNEL_WIDTH  = 8,
    parameter int CHANNELS       = 3,
    parameter int PIX_PER_BEAT   = 4,
    parameter int DST_IMG_WIDTH  = 3840,
    parameter int DST_IMG_HEIGHT = 2160,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    bcci_axis_out_packer_if.master        bus,
    output logic                          busy,
    output logic                          frame_done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW    = CHANNELS * CHANNEL_WIDTH;
    localparam int DW    = PIX_PER_BEAT * PW;
    localparam int KW    = DW / 8;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LW    = AW + 1;
    localparam int EW    = DW + KW + 2;
    localparam int PIX_W = (PIX_PER_BEAT > 1) ? $clog2(PIX_PER_BEAT) : 1;
    localparam int COL_W = (DST_IMG_WIDTH > 1) ? $clog2(DST_IMG_WIDTH) : 1;
    localparam int ROW_W = (DST_IMG_HEIGHT > 1) ? $clog2(DST_IMG_HEIGHT) : 1;

    localparam logic [PIX_W-1:0] PIX_LAST   = PIX_W'(PIX_PER_BEAT - 1);
    localparam logic [PIX_W-1:0] PIX_ONE    = PIX_W'(1);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(DST_IMG_WIDTH - 1);
    localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(DST_IMG_HEIGHT - 1);
    localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);
    localparam logic [AW-1:0]    PTR_ONE    = AW'(1);
    localparam logic [LW-1:0]    LVL_ONE    = LW'(1);
    localparam logic [LW-1:0]    LEVEL_FULL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [PIX_W-1:0] pix_idx_q, pix_idx_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             first_q, first_d;
    logic [PW-1:0]    acc_q [PIX_PER_BEAT];
    logic [PW-1:0]    acc_d [PIX_PER_BEAT];
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             in_ready_q, in_ready_d;
    logic             tvalid_q, tvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_s, push_s, pop_s;
    logic [DW-1:0]    beat_data_s;
    logic [KW-1:0]    beat_keep_s;
    logic [EW-1:0]    head_s;
    int               n_bytes_s;

    assign accept_s = bus.in_valid & in_ready_q;
    assign push_s   = accept_s & ((pix_idx_q == PIX_LAST) | (col_q == COL_LAST));
    assign pop_s    = tvalid_q & bus.m_axis_tready;

    // Assemble the outgoing beat: stored slots below pix_idx, the live pixel, zeros above.
    always_comb begin
        beat_data_s = '0;
        beat_keep_s = '0;
        n_bytes_s   = ((int'(pix_idx_q) + 1) * PW) / 8;
        for (int i = 0; i < PIX_PER_BEAT; i++) begin
            if (i < int'(pix_idx_q)) begin
                beat_data_s[i*PW +: PW] = acc_q[i];
            end else if (i == int'(pix_idx_q)) begin
                beat_data_s[i*PW +: PW] = bus.in_data;
            end else begin
                beat_data_s[i*PW +: PW] = '0;
            end
        end
        for (int b = 0; b < KW; b++) begin
            beat_keep_s[b] = (b < n_bytes_s) ? 1'b1 : 1'b0;
        end
    end

    // Beat FIFO bookkeeping: write on beat completion, read on downstream handshake.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = {first_q, (col_q == COL_LAST), beat_keep_s, beat_data_s};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Frame FSM, raster counters and accumulator; outputs are derived from next state.
    always_comb begin
        state_d   = state_q;
        pix_idx_d = pix_idx_q;
        col_d     = col_q;
        row_d     = row_q;
        first_d   = first_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACTIVE;
                    pix_idx_d = '0;
                    col_d     = '0;
                    row_d     = '0;
                    first_d   = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ACTIVE: begin
                if (accept_s) begin
                    acc_d[pix_idx_q] = bus.in_data;
                    if (push_s) begin
                        pix_idx_d = '0;
                        first_d   = 1'b0;
                    end else begin
                        pix_idx_d = pix_idx_q + PIX_ONE;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + ROW_ONE;
                        end
                    end else begin
                        col_d = col_q + COL_ONE;
                    end
                end else begin
                    state_d = ACTIVE;
                end
            end
            DRAIN: begin
                // Finishing on the next-cycle level places frame_done right after the last handshake.
                if (level_d == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == ACTIVE) && (level_d != LEVEL_FULL);
        tvalid_d   = (level_d != '0);
        busy_d     = (state_d != IDLE);
    end

    // State registers with asynchronous clear of FIFO, accumulator and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pix_idx_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            first_q    <= 1'b0;
            acc_q      <= '{default: '0};
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b0;
            tvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_idx_q  <= pix_idx_d;
            col_q      <= col_d;
            row_q      <= row_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            tvalid_q   <= tvalid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign head_s            = mem_q[rd_ptr_q];
    assign bus.in_ready      = in_ready_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tdata  = head_s[DW-1:0];
    assign bus.m_axis_tkeep  = head_s[DW +: KW];
    assign bus.m_axis_tlast  = head_s[DW+KW];
    assign bus.m_axis_tuser  = head_s[DW+KW+1];
    assign busy              = busy_q;
    assign frame_done        = done_q;
    assign fifo_level        = level_q;
endmodule

// File: tb/tb_bcci_axis_out_packer.sv
// Self-checking bench: two packer instances (8x4 lines with a 4-deep FIFO, and a
// 6x1 line exercising partial beats) compared against a raster-level beat model.
module tb_bcci_axis_out_packer;
    localparam int PPB   = 4;
    localparam int LIMIT = 4000;

    typedef struct packed {
        logic        user;
        logic        last;
        logic [11:0] keep;
        logic [95:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tb_start = 1'b0;
    logic        tb_valid = 1'b0;
    logic [23:0] tb_data = 24'h0;
    logic        tb_tready = 1'b0;
    logic        sel_b = 1'b0;

    logic        busy_a, busy_b, done_a, done_b;
    logic [2:0]  lvl_a;
    logic [4:0]  lvl_b;

    bcci_axis_out_packer_if #(.PW(24), .DW(96)) ifa ();
    bcci_axis_out_packer_if #(.PW(24), .DW(96)) ifb ();

    assign ifa.in_valid      = tb_valid & ~sel_b;
    assign ifb.in_valid      = tb_valid & sel_b;
    assign ifa.in_data       = tb_data;
    assign ifb.in_data       = tb_data;
    assign ifa.m_axis_tready = tb_tready;
    assign ifb.m_axis_tready = tb_tready;

    bcci_axis_out_packer #(.CHANNEL_WIDTH(8), .CHANNELS(3), .PIX_PER_BEAT(4),
        .DST_IMG_WIDTH(8), .DST_IMG_HEIGHT(4), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(tb_start & ~sel_b), .bus(ifa.master),
        .busy(busy_a), .frame_done(done_a), .fifo_level(lvl_a));

    bcci_axis_out_packer #(.CHANNEL_WIDTH(8), .CHANNELS(3), .PIX_PER_BEAT(4),
        .DST_IMG_WIDTH(6), .DST_IMG_HEIGHT(1), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .rst(rst), .start(tb_start & sel_b), .bus(ifb.master),
        .busy(busy_b), .frame_done(done_b), .fifo_level(lvl_b));

    logic        cur_in_ready, cur_tvalid, cur_busy, cur_done;
    logic [4:0]  cur_level;
    beat_t       cur_beat;

    assign cur_in_ready = sel_b ? ifb.in_ready : ifa.in_ready;
    assign cur_tvalid   = sel_b ? ifb.m_axis_tvalid : ifa.m_axis_tvalid;
    assign cur_busy     = sel_b ? busy_b : busy_a;
    assign cur_done     = sel_b ? done_b : done_a;
    assign cur_level    = sel_b ? lvl_b : {2'b00, lvl_a};
    assign cur_beat     = sel_b ? {ifb.m_axis_tuser, ifb.m_axis_tlast, ifb.m_axis_tkeep, ifb.m_axis_tdata}
                                : {ifa.m_axis_tuser, ifa.m_axis_tlast, ifa.m_axis_tkeep, ifa.m_axis_tdata};

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cur_w = 8;
    int          cur_h = 4;
    int          done_cnt = 0;
    int          done_base = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    int          first_hs_cyc = 0;
    int          acc_cyc = 0;
    logic        busy_at_done = 1'b1;
    logic [23:0] px_q[$];
    beat_t       obs_q[$];
    beat_t       exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records handshaken beats and frame_done pulses mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (cur_tvalid && tb_tready) begin
                if (obs_q.size() == 0) first_hs_cyc <= cyc;
                obs_q.push_back(cur_beat);
                last_hs_cyc <= cyc;
            end
            if (cur_done) begin
                done_cnt     <= done_cnt + 1;
                done_cyc     <= cyc;
                busy_at_done <= cur_busy;
            end
        end
    end

    // Reference: walk the raster, cutting beats at PPB pixels or at end of line.
    function automatic void model_frame();
        beat_t b;
        int    n;
        exp_q.delete();
        for (int r = 0; r < cur_h; r++) begin
            for (int c = 0; c < cur_w; c += PPB) begin
                n = (cur_w - c < PPB) ? (cur_w - c) : PPB;
                b = '0;
                for (int j = 0; j < n; j++) b.data[j*24 +: 24] = px_q[r*cur_w + c + j];
                b.keep = 12'((1 << (n * 3)) - 1);
                b.last = (c + n == cur_w);
                b.user = (r == 0 && c == 0);
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic gen_pixels(input bit pattern);
        px_q.delete();
        for (int i = 0; i < cur_w * cur_h; i++) begin
            if (pattern) px_q.push_back({8'(i), 8'(i), 8'(i)});
            else         px_q.push_back(24'($urandom));
        end
    endtask

    task automatic prep_frame();
        obs_q.delete();
        done_base = done_cnt;
    endtask

    task automatic pulse_start();
        prep_frame();
        tb_start = 1'b1;
        @(posedge clk); #1;
        tb_start = 1'b0;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic drive_pixels(input int from, input int to, input bit rnd, input bit wait_done);
        int k;
        int guard;
        k = from;
        guard = 0;
        while ((k < to || (wait_done && done_cnt == done_base)) && guard < LIMIT) begin
            if (k < to) begin
                tb_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                tb_data  = px_q[k];
            end else begin
                tb_valid = 1'b0;
                tb_data  = 24'h0;
            end
            if (rnd) tb_tready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (tb_valid && cur_in_ready) begin
                if (k == PPB - 1) acc_cyc = cyc;
                k++;
            end
            @(posedge clk); #1;
            guard++;
        end
        tb_valid = 1'b0;
        if (rnd) tb_tready = 1'b1;
        if (guard >= LIMIT) begin
            total++; bad++;
            $display("FAIL drive_timeout got k=%0d done=%0d exp k=%0d frame_done", k, done_cnt - done_base, to);
        end
    endtask

    task automatic check_frame(input string name);
        model_frame();
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL %s_beat_count got=%0d exp=%0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            total++;
            if (obs_q[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL %s_beat%0d got=%h exp=%h", name, i, obs_q[i], exp_q[i]);
            end
        end
        total++;
        if (done_cnt - done_base != 1) begin
            bad++;
            $display("FAIL %s_done_pulses got=%0d exp=1", name, done_cnt - done_base);
        end
        total++;
        if (done_cyc != last_hs_cyc + 1) begin
            bad++;
            $display("FAIL %s_done_timing got=%0d exp=%0d", name, done_cyc, last_hs_cyc + 1);
        end
        total++;
        if (busy_at_done !== 1'b0) begin
            bad++;
            $display("FAIL %s_busy_at_done got=%b exp=0", name, busy_at_done);
        end
    endtask

    task automatic check_idle_outputs(input string name);
        total++;
        if ({cur_in_ready, cur_tvalid, cur_beat.last, cur_beat.user, cur_busy, cur_done} !== 6'b0) begin
            bad++;
            $display("FAIL %s_ctrl got=%b exp=000000", name,
                     {cur_in_ready, cur_tvalid, cur_beat.last, cur_beat.user, cur_busy, cur_done});
        end
        total++;
        if (cur_beat.data !== 96'h0 || cur_beat.keep !== 12'h0) begin
            bad++;
            $display("FAIL %s_data got=%h/%h exp=0/0", name, cur_beat.data, cur_beat.keep);
        end
        total++;
        if (cur_level !== 5'd0) begin
            bad++;
            $display("FAIL %s_level got=%0d exp=0", name, cur_level);
        end
    endtask

    task automatic test_reset();
        #12;
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("after_reset");
    endtask

    task automatic test_frame_basic();
        sel_b = 1'b0; cur_w = 8; cur_h = 4; tb_tready = 1'b1;
        gen_pixels(1'b1);
        prep_frame();
        tb_start = 1'b1;
        @(negedge clk);
        total++;
        if (cur_in_ready !== 1'b0) begin bad++; $display("FAIL ready_on_start got=%b exp=0", cur_in_ready); end
        @(posedge clk); #1;
        tb_start = 1'b0;
        @(negedge clk);
        total++;
        if (cur_in_ready !== 1'b1) begin bad++; $display("FAIL ready_after_start got=%b exp=1", cur_in_ready); end
        @(posedge clk); #1;
        drive_pixels(0, 32, 1'b0, 1'b1);
        check_frame("basic");
        total++;
        if (first_hs_cyc != acc_cyc + 1) begin
            bad++; $display("FAIL beat_latency got=%0d exp=%0d", first_hs_cyc, acc_cyc + 1);
        end
        total++;
        if (obs_q.size() < 2 || obs_q[0].data[23:0] !== 24'h000000 || obs_q[1].data[23:0] !== 24'h040404) begin
            bad++; $display("FAIL pixel0_lsb got=%0d beats exp=000000/040404 at lsb", obs_q.size());
        end
    endtask

    task automatic test_partial_beat();
        sel_b = 1'b1; cur_w = 6; cur_h = 1; tb_tready = 1'b1;
        gen_pixels(1'b1);
        pulse_start();
        drive_pixels(0, 6, 1'b0, 1'b1);
        check_frame("partial");
        total++;
        if (obs_q.size() != 2) begin
            bad++; $display("FAIL partial_size got=%0d exp=2", obs_q.size());
        end else if (obs_q[1].keep !== 12'h03F || obs_q[1].data[95:48] !== 48'h0 || obs_q[1].last !== 1'b1) begin
            bad++; $display("FAIL partial_tail got=%h exp keep=03f upper=0 last=1", obs_q[1]);
        end
        sel_b = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic took;
        sel_b = 1'b0; cur_w = 8; cur_h = 4; tb_tready = 1'b0;
        gen_pixels(1'b0);
        pulse_start();
        drive_pixels(0, 16, 1'b0, 1'b0);
        tb_valid = 1'b1; tb_data = px_q[16];
        repeat (3) @(negedge clk);
        total++;
        if (cur_level !== 5'd4 || cur_in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_full got level=%0d ready=%b exp level=4 ready=0", cur_level, cur_in_ready);
        end
        @(posedge clk); #1;
        tb_tready = 1'b1;
        @(negedge clk);
        total++;
        if (cur_level !== 5'd4 || cur_in_ready !== 1'b0) begin
            bad++; $display("FAIL bp_pop_cycle got level=%0d ready=%b exp level=4 ready=0", cur_level, cur_in_ready);
        end
        @(negedge clk);
        total++;
        if (cur_level !== 5'd3 || cur_in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release got level=%0d ready=%b exp level=3 ready=1", cur_level, cur_in_ready);
        end
        took = cur_in_ready;
        @(posedge clk); #1;
        drive_pixels(took ? 17 : 16, 32, 1'b0, 1'b1);
        check_frame("backpressure");
    endtask

    task automatic test_control();
        sel_b = 1'b0; cur_w = 8; cur_h = 4; tb_tready = 1'b1;
        obs_q.delete();
        tb_valid = 1'b1; tb_data = 24'hABCDEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (cur_in_ready !== 1'b0) begin bad++; $display("FAIL idle_ready cyc%0d got=%b exp=0", i, cur_in_ready); end
        end
        @(posedge clk); #1;
        tb_valid = 1'b0;
        total++;
        if (cur_level !== 5'd0 || obs_q.size() != 0) begin
            bad++; $display("FAIL idle_push got level=%0d beats=%0d exp=0/0", cur_level, obs_q.size());
        end
        gen_pixels(1'b0);
        pulse_start();
        drive_pixels(0, 10, 1'b0, 1'b0);
        tb_start = 1'b1;
        drive_pixels(10, 11, 1'b0, 1'b0);
        tb_start = 1'b0;
        total++;
        if (cur_busy !== 1'b1) begin bad++; $display("FAIL busy_mid got=%b exp=1", cur_busy); end
        drive_pixels(11, 32, 1'b0, 1'b1);
        check_frame("second_start");
    endtask

    task automatic test_reset_mid_frame();
        sel_b = 1'b0; cur_w = 8; cur_h = 4; tb_tready = 1'b0;
        gen_pixels(1'b0);
        pulse_start();
        drive_pixels(0, 5, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tb_tready = 1'b1;
        @(posedge clk); #1;
        gen_pixels(1'b0);
        pulse_start();
        drive_pixels(0, 32, 1'b0, 1'b1);
        check_frame("after_mid_reset");
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            sel_b = 1'b0; cur_w = 8; cur_h = 4;
            gen_pixels(1'b0);
            pulse_start();
            drive_pixels(0, 32, 1'b1, 1'b1);
            check_frame($sformatf("rand_a%0d", f));
        end
        for (int f = 0; f < 2; f++) begin
            sel_b = 1'b1; cur_w = 6; cur_h = 1;
            gen_pixels(1'b0);
            pulse_start();
            drive_pixels(0, 6, 1'b1, 1'b1);
            check_frame($sformatf("rand_b%0d", f));
        end
        sel_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame_basic();
        test_partial_beat();
        test_back_pressure();
        test_control();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
